// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a bounded hold time: one registered grant at a time,
// a mandatory idle cycle after every release, and a rotating priority pointer.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 any_req
);

   localparam int ID_W = $clog2(N);
   localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N - 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_r;
   logic [ID_W-1:0] ptr_r;
   logic [HC_W-1:0] hold_cnt_r;
   logic [N-1:0]    gnt_r;
   logic            gnt_valid_r;
   logic [ID_W-1:0] gnt_id_r;

   logic [ID_W-1:0] pick_id_s;
   logic            pick_found_s;
   logic            release_s;

   function automatic logic [N-1:0] to_onehot(input logic [ID_W-1:0] id);
      logic [N-1:0] v;
      v     = {N{1'b0}};
      v[id] = 1'b1;
      return v;
   endfunction

   // Request presence is purely combinational so it follows req even in reset
   assign any_req   = |req;
   assign gnt       = gnt_r;
   assign gnt_valid = gnt_valid_r;
   assign gnt_id    = gnt_id_r;

   // Owner gives up the grant when it drops its request or its time slice ends
   assign release_s = (req[gnt_id_r] == 1'b0) || (hold_cnt_r == HOLD_LAST);

   // First requester at or after the pointer, wrapping around
   always_comb begin : pick_search
      int idx_v;
      idx_v        = 0;
      pick_id_s    = {ID_W{1'b0}};
      pick_found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx_v = (int'(ptr_r) + i) % N;
         if (!pick_found_s && req[ID_W'(idx_v)]) begin
            pick_found_s = 1'b1;
            pick_id_s    = ID_W'(idx_v);
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Arbitration state machine with registered grant outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= {ID_W{1'b0}};
         hold_cnt_r  <= {HC_W{1'b0}};
         gnt_r       <= {N{1'b0}};
         gnt_valid_r <= 1'b0;
         gnt_id_r    <= {ID_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  gnt_r       <= to_onehot(pick_id_s);
                  gnt_valid_r <= 1'b1;
                  gnt_id_r    <= pick_id_s;
                  hold_cnt_r  <= {HC_W{1'b0}};
                  state_r     <= BUSY;
               end else begin
                  gnt_r       <= {N{1'b0}};
                  gnt_valid_r <= 1'b0;
               end
            end
            BUSY: begin
               if (release_s) begin
                  // Releasing owner moves to lowest priority
                  gnt_r       <= {N{1'b0}};
                  gnt_valid_r <= 1'b0;
                  ptr_r       <= (gnt_id_r == LAST_ID) ? {ID_W{1'b0}} : (gnt_id_r + ID_W'(1));
                  hold_cnt_r  <= {HC_W{1'b0}};
                  state_r     <= IDLE;
               end else begin
                  hold_cnt_r  <= hold_cnt_r + HC_W'(1);
               end
            end
            default: begin
               gnt_r       <= {N{1'b0}};
               gnt_valid_r <= 1'b0;
               hold_cnt_r  <= {HC_W{1'b0}};
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters; legal range N >= 2.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, maximum consecutive cycles one grant is held; legal range MAX_HOLD >= 1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req  input  N  per-requester request level, bit i = requester i.
REQ-006 The block SHALL have port gnt  output  N  registered grant, one-hot or all-zero.
REQ-007 The block SHALL have port gnt_valid  output  1  registered; high iff gnt != 0.
REQ-008 The block SHALL have port gnt_id  output  $clog2(N)  registered index of the granted requester; holds last owner when gnt_valid=0.
REQ-009 The block SHALL have port any_req  output  1  combinational OR-reduction of req; no clock dependence.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant active).
REQ-011 The block SHALL keep a round-robin pointer ptr (width $clog2(N)) marking the highest-priority requester.
REQ-012 In IDLE with any_req=1, the block SHALL select the first set req bit searching ptr, ptr+1, ... wrapping modulo N, and assert its gnt bit on the next rising edge; state -> BUSY.
REQ-013 In IDLE with any_req=0, the block SHALL remain in IDLE with gnt=0.
REQ-014 Grant latency SHALL be exactly 1 cycle from the sampling edge at which req is seen in IDLE.
REQ-015 In BUSY, the block SHALL keep gnt unchanged while req[gnt_id]=1 and hold_cnt < MAX_HOLD-1.
REQ-016 hold_cnt SHALL be 0 in the first granted cycle and increment by 1 per BUSY cycle; it SHALL never exceed MAX_HOLD-1.
REQ-017 In BUSY, the block SHALL release when req[gnt_id]=0 or hold_cnt = MAX_HOLD-1 (forced release), whichever first.
REQ-018 On release, the next edge SHALL clear gnt and gnt_valid, set ptr = (gnt_id+1) mod N, clear hold_cnt, and enter IDLE.
REQ-019 Every release SHALL produce exactly one idle cycle (gnt=0) before any new grant; back-to-back grants without a gap are forbidden.
REQ-020 While BUSY, changes on req bits other than gnt_id SHALL be ignored.
REQ-021 A forced release SHALL occur even if the owner keeps req high; the owner then has lowest priority at the next arbitration.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-023 ptr wrap-around: owner N-1 released SHALL set ptr=0.

Reset
REQ-024 While rst=1, the block SHALL asynchronously force gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold_cnt=0, state=IDLE.
REQ-025 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-026 On the first rising edge after rst deasserts, the block SHALL arbitrate normally from ptr=0.
REQ-027 any_req SHALL track req during reset.

Verification (N=4, MAX_HOLD=8)
REQ-028 Bench SHALL cover: reset release, req=4'b0000 -> gnt=0, gnt_valid=0, any_req=0; then req=4'b0100 -> any_req=1 immediately, gnt=4'b0100, gnt_id=2 one edge later.
REQ-029 Bench SHALL cover: req=4'b1111 held constantly -> grants in order id 0,1,2,3,0, each lasting 8 cycles, each followed by 1 cycle of gnt=0.
REQ-030 Bench SHALL cover: owner 1 drops req after 3 granted cycles while req=4'b1011 -> gnt=0 one cycle, then gnt=4'b1000 (ptr=2, search finds 3).
REQ-031 Bench SHALL cover: grant to id 3 released -> ptr=0; with req=4'b1001 next grant is id 0 (wrap-around).
REQ-032 Bench SHALL cover: rst pulsed mid-grant (gnt=4'b0010) between clock edges -> gnt=0, gnt_valid=0 before next edge; after release with req=4'b0010, gnt=4'b0010 from ptr=0.
REQ-033 Bench SHALL cover: assertion at every edge that gnt is one-hot or zero, gnt_valid == (gnt != 0), and no grant exceeds 8 consecutive cycles.
